// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: BCD digit width, per-digit roll-over limits
// and the 2-bit state encoding.
package stopwatch_pkg;

   localparam int unsigned BCD_W = 4;

   localparam int unsigned DIGIT_LIMIT_DEC = 9;
   localparam int unsigned DIGIT_LIMIT_SEX = 5;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StRun    = 2'd1;
   localparam logic [1:0] StPaused = 2'd2;
   localparam logic [1:0] StLap    = 2'd3;

   // Two-digit BCD image of a 0..99 integer, used for the minute limit.
   function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned value);
      return {BCD_W'(value / 10), BCD_W'(value % 10)};
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..LIMIT and carries out when it rolls over.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned LIMIT = DIGIT_LIMIT_DEC
) (
   input  logic             clk_in,
   input  logic             res,
   input  logic             inc,
   input  logic             clr,
   output logic [BCD_W-1:0] digit,
   output logic             carry
);

   localparam logic [BCD_W-1:0] LimitBcd = BCD_W'(LIMIT);

   logic [BCD_W-1:0] digit_d, digit_q;
   logic             at_limit;

   always_comb begin
      at_limit = (digit_q == LimitBcd);
      digit_d  = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (inc) begin
         digit_d = at_limit ? '0 : digit_q + BCD_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (res) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign carry = inc & at_limit;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch MM:SS.cc counting qualified rising edges of tick_in, with a
// start/stop/lap/clear state machine and a registered 6-digit BCD display.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned MIN_MAX = 59
) (
   input  logic               clk_in,
   input  logic               res,
   input  logic               ena,
   input  logic               tick_in,
   input  logic               start_stop,
   input  logic               lap_clear,
   output logic [6*BCD_W-1:0] display,
   output logic               running,
   output logic               lap_active,
   output logic               wrap
);

   localparam logic [2*BCD_W-1:0] MinMaxBcd = to_bcd2(MIN_MAX);

   logic [1:0]           state_d, state_q;
   logic                 tick_q;
   logic [2*BCD_W-1:0]   min_d, min_q;
   logic [6*BCD_W-1:0]   snapshot_d, snapshot_q;
   logic [6*BCD_W-1:0]   display_d, display_q;
   logic                 running_d, running_q;
   logic                 lap_d, lap_q;
   logic                 wrap_d, wrap_q;

   logic                 tick_edge, adv, clr_cnt, min_at_max;
   logic [BCD_W-1:0]     cs_o, cs_t, sec_o, sec_t;
   logic                 cs_o_carry, cs_t_carry, sec_o_carry, sec_t_carry;
   logic [6*BCD_W-1:0]   live;

   assign live = {min_q, sec_t, sec_o, cs_t, cs_o};

   always_comb begin
      tick_edge  = tick_in & ~tick_q;
      adv        = ena & tick_edge & ((state_q == StRun) || (state_q == StLap));
      state_d    = state_q;
      snapshot_d = snapshot_q;
      clr_cnt    = 1'b0;
      // start_stop is tested first in every state so it wins over lap_clear.
      if (ena) begin
         case (state_q)
            StIdle: begin
               if (start_stop) state_d = StRun;
            end
            StRun: begin
               if (start_stop) begin
                  state_d = StPaused;
               end else if (lap_clear) begin
                  state_d    = StLap;
                  snapshot_d = live;
               end
            end
            StLap: begin
               if (start_stop) begin
                  state_d = StPaused;
               end else if (lap_clear) begin
                  state_d = StRun;
               end
            end
            StPaused: begin
               if (start_stop) begin
                  state_d = StRun;
               end else if (lap_clear) begin
                  state_d = StIdle;
                  clr_cnt = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   bcd_digit_counter #(.LIMIT(DIGIT_LIMIT_DEC)) u_cs_o (
      .clk_in (clk_in),
      .res    (res),
      .inc    (adv),
      .clr    (clr_cnt),
      .digit  (cs_o),
      .carry  (cs_o_carry)
   );

   bcd_digit_counter #(.LIMIT(DIGIT_LIMIT_DEC)) u_cs_t (
      .clk_in (clk_in),
      .res    (res),
      .inc    (cs_o_carry),
      .clr    (clr_cnt),
      .digit  (cs_t),
      .carry  (cs_t_carry)
   );

   bcd_digit_counter #(.LIMIT(DIGIT_LIMIT_DEC)) u_sec_o (
      .clk_in (clk_in),
      .res    (res),
      .inc    (cs_t_carry),
      .clr    (clr_cnt),
      .digit  (sec_o),
      .carry  (sec_o_carry)
   );

   bcd_digit_counter #(.LIMIT(DIGIT_LIMIT_SEX)) u_sec_t (
      .clk_in (clk_in),
      .res    (res),
      .inc    (sec_o_carry),
      .clr    (clr_cnt),
      .digit  (sec_t),
      .carry  (sec_t_carry)
   );

   // Minutes are a BCD pair that wraps at MIN_MAX rather than at 99.
   always_comb begin
      min_at_max = (min_q == MinMaxBcd);
      min_d      = min_q;
      if (clr_cnt) begin
         min_d = '0;
      end else if (sec_t_carry) begin
         if (min_at_max) begin
            min_d = '0;
         end else if (min_q[BCD_W-1:0] == BCD_W'(DIGIT_LIMIT_DEC)) begin
            min_d = {min_q[2*BCD_W-1:BCD_W] + BCD_W'(1), BCD_W'(0)};
         end else begin
            min_d = {min_q[2*BCD_W-1:BCD_W], min_q[BCD_W-1:0] + BCD_W'(1)};
         end
      end
      wrap_d = sec_t_carry & min_at_max;
   end

   always_comb begin
      display_d = (state_q == StLap) ? snapshot_q : live;
      running_d = (state_d == StRun) || (state_d == StLap);
      lap_d     = (state_d == StLap);
   end

   always_ff @(posedge clk_in) begin
      if (res) begin
         state_q    <= StIdle;
         tick_q     <= 1'b1;
         min_q      <= '0;
         snapshot_q <= '0;
         display_q  <= '0;
         running_q  <= 1'b0;
         lap_q      <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_in;
         min_q      <= min_d;
         snapshot_q <= snapshot_d;
         display_q  <= display_d;
         running_q  <= running_d;
         lap_q      <= lap_d;
         wrap_q     <= wrap_d;
      end
   end

   assign display    = display_q;
   assign running    = running_q;
   assign lap_active = lap_q;
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: stimulus queues expected outputs, a monitor
// pops and compares them on the falling edge. A second instance wraps at 01:59.99.
module tb_stopwatch_core;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        ena = 1'b1;
   logic        tick_in = 1'b1;
   logic        start_stop = 1'b0;
   logic        lap_clear = 1'b0;

   logic [23:0] disp0, disp1;
   logic        run0, run1, lap0, lap1, wrap0, wrap1;

   int total = 0;
   int bad = 0;

   typedef struct {
      string       name;
      bit          sel;
      logic [23:0] disp;
      logic        run;
      logic        lap;
      logic        wr;
   } exp_t;

   exp_t exp_q[$];

   stopwatch_core dut (
      .clk_in     (clk),
      .res        (res),
      .ena        (ena),
      .tick_in    (tick_in),
      .start_stop (start_stop),
      .lap_clear  (lap_clear),
      .display    (disp0),
      .running    (run0),
      .lap_active (lap0),
      .wrap       (wrap0)
   );

   stopwatch_core #(.MIN_MAX(1)) dut_w (
      .clk_in     (clk),
      .res        (res),
      .ena        (ena),
      .tick_in    (tick_in),
      .start_stop (start_stop),
      .lap_clear  (lap_clear),
      .display    (disp1),
      .running    (run1),
      .lap_active (lap1),
      .wrap       (wrap1)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input string field, input logic [23:0] got,
                      input logic [23:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s.%s got=%h want=%h", name, field, got, want);
      end
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (!e.sel) begin
            cmp(e.name, "display", disp0, e.disp);
            cmp(e.name, "running", {23'd0, run0}, {23'd0, e.run});
            cmp(e.name, "lap_active", {23'd0, lap0}, {23'd0, e.lap});
            cmp(e.name, "wrap", {23'd0, wrap0}, {23'd0, e.wr});
         end else begin
            cmp(e.name, "w.display", disp1, e.disp);
            cmp(e.name, "w.running", {23'd0, run1}, {23'd0, e.run});
            cmp(e.name, "w.lap_active", {23'd0, lap1}, {23'd0, e.lap});
            cmp(e.name, "w.wrap", {23'd0, wrap1}, {23'd0, e.wr});
         end
      end
   end

   // Inputs change just after the falling edge; one call covers one rising edge.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic push_exp(input string name, input bit sel, input logic [23:0] d,
                           input logic r, input logic l, input logic w);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.disp = d;
      e.run  = r;
      e.lap  = l;
      e.wr   = w;
      exp_q.push_back(e);
   endtask

   // Expected outputs after the next rising edge with the current inputs applied.
   task automatic chk(input string name, input logic [23:0] d, input logic r,
                      input logic l, input logic w);
      push_exp(name, 1'b0, d, r, l, w);
      cyc();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_in = 1'b1;
         cyc();
         tick_in = 1'b0;
         cyc();
      end
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      cyc();
      start_stop = 1'b0;
   endtask

   task automatic pulse_lc();
      lap_clear = 1'b1;
      cyc();
      lap_clear = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with tick_in already high.
      push_exp("reset_w", 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0);
      chk("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
      res = 1'b0;
      chk("post_reset_tick_high", 24'h000000, 1'b0, 1'b0, 1'b0);
      tick_in = 1'b0;
      ticks(5);
      chk("idle_ticks_ignored", 24'h000000, 1'b0, 1'b0, 1'b0);
      pulse_ss();
      chk("start", 24'h000000, 1'b1, 1'b0, 1'b0);

      // Counting and digit roll-overs.
      ticks(99);
      chk("cnt_0099", 24'h000099, 1'b1, 1'b0, 1'b0);
      ticks(1);
      chk("cs_to_sec", 24'h000100, 1'b1, 1'b0, 1'b0);
      ticks(150);
      chk("cnt_0250", 24'h000250, 1'b1, 1'b0, 1'b0);
      ticks(5749);
      chk("cnt_5999", 24'h005999, 1'b1, 1'b0, 1'b0);
      ticks(1);
      chk("sec_to_min", 24'h010000, 1'b1, 1'b0, 1'b0);
      ticks(5999);
      push_exp("pre_wrap_w", 1'b1, 24'h015999, 1'b1, 1'b0, 1'b0);
      chk("cnt_15999", 24'h015999, 1'b1, 1'b0, 1'b0);
      tick_in = 1'b1;
      push_exp("wrap_pulse_w", 1'b1, 24'h015999, 1'b1, 1'b0, 1'b1);
      chk("no_wrap_at_1", 24'h015999, 1'b1, 1'b0, 1'b0);
      tick_in = 1'b0;
      push_exp("wrapped_w", 1'b1, 24'h000000, 1'b1, 1'b0, 1'b0);
      chk("min_2", 24'h020000, 1'b1, 1'b0, 1'b0);
      ticks(1);
      push_exp("after_wrap_w", 1'b1, 24'h000001, 1'b1, 1'b0, 1'b0);
      chk("cnt_20001", 24'h020001, 1'b1, 1'b0, 1'b0);

      // Pause, clear to idle, lap_clear ignored in idle.
      pulse_ss();
      chk("pause", 24'h020001, 1'b0, 1'b0, 1'b0);
      ticks(100);
      chk("pause_holds", 24'h020001, 1'b0, 1'b0, 1'b0);
      pulse_lc();
      chk("clear", 24'h000000, 1'b0, 1'b0, 1'b0);
      pulse_lc();
      chk("idle_lc_ignored", 24'h000000, 1'b0, 1'b0, 1'b0);
      pulse_ss();
      chk("restart", 24'h000000, 1'b1, 1'b0, 1'b0);

      // Lap freeze and release.
      ticks(317);
      chk("cnt_0317", 24'h000317, 1'b1, 1'b0, 1'b0);
      pulse_lc();
      chk("lap_enter", 24'h000317, 1'b1, 1'b1, 1'b0);
      ticks(50);
      chk("lap_frozen", 24'h000317, 1'b1, 1'b1, 1'b0);
      pulse_lc();
      chk("lap_release", 24'h000367, 1'b1, 1'b0, 1'b0);

      // Simultaneous buttons and ticks coincident with state changes.
      start_stop = 1'b1;
      lap_clear  = 1'b1;
      chk("both_buttons", 24'h000367, 1'b0, 1'b0, 1'b0);
      start_stop = 1'b0;
      lap_clear  = 1'b0;
      pulse_ss();
      chk("resume", 24'h000367, 1'b1, 1'b0, 1'b0);
      tick_in    = 1'b1;
      start_stop = 1'b1;
      cyc();
      start_stop = 1'b0;
      tick_in    = 1'b0;
      chk("tick_with_stop", 24'h000368, 1'b0, 1'b0, 1'b0);
      tick_in    = 1'b1;
      start_stop = 1'b1;
      cyc();
      start_stop = 1'b0;
      tick_in    = 1'b0;
      chk("tick_with_start", 24'h000368, 1'b1, 1'b0, 1'b0);
      tick_in   = 1'b1;
      lap_clear = 1'b1;
      cyc();
      lap_clear = 1'b0;
      tick_in   = 1'b0;
      chk("tick_with_lap", 24'h000368, 1'b1, 1'b1, 1'b0);
      pulse_lc();
      chk("lap_release2", 24'h000369, 1'b1, 1'b0, 1'b0);

      // Enable low holds everything; a level already high on re-enable is not a tick.
      ena = 1'b0;
      ticks(10);
      pulse_ss();
      pulse_lc();
      chk("ena_low_hold", 24'h000369, 1'b1, 1'b0, 1'b0);
      tick_in = 1'b1;
      cyc();
      ena = 1'b1;
      chk("ena_high_level", 24'h000369, 1'b1, 1'b0, 1'b0);
      tick_in = 1'b0;
      cyc();
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      chk("ena_next_edge", 24'h000370, 1'b1, 1'b0, 1'b0);

      // Reset mid-run with a tick and a button pending.
      res        = 1'b1;
      tick_in    = 1'b1;
      start_stop = 1'b1;
      push_exp("mid_reset_w", 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0);
      chk("mid_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
      res        = 1'b0;
      start_stop = 1'b0;

      cyc();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
